kronos_dmem: RTL

KRONOS_DMEM -- requirements
Module: kronos_dmem

---
 rtl/kronos_dmem.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/kronos_dmem.sv
// Word-addressed data memory with byte-lane writes, programmable wait states and
// a single-cycle grant/error handshake.
module kronos_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  output logic [31:0] data_rd_data,
  output logic        data_gnt,
  output logic        data_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         mask_q;
  logic               wr_q;
  logic [31:0]        mem [DEPTH];

  logic [31:0]        acc_addr;
  logic               acc_wr;
  logic [32:0]        acc_off;
  logic               acc_in_range;
  logic [IDX_W-1:0]   acc_idx;
  logic               gnt_d, err_d, rd_load, mem_we;

  // Live request while accepting (needed for zero wait states), latched copy afterwards
  always_comb begin
    acc_addr     = (state_q == ST_IDLE) ? (data_addr & 32'hFFFF_FFFC) : (addr_q & 32'hFFFF_FFFC);
    acc_wr       = (state_q == ST_IDLE) ? data_wr_req : wr_q;
    acc_off      = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    acc_in_range = (acc_addr >= BASE_ADDR) && (acc_off < SPAN);
    acc_idx      = acc_off[IDX_W+1:2];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (data_rd_req || data_wr_req) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: grant/read load on entry to RESP, array write during RESP
  always_comb begin
    gnt_d   = 1'b0;
    err_d   = 1'b0;
    rd_load = 1'b0;
    mem_we  = 1'b0;
    if (state_d == ST_RESP) begin
      gnt_d   = 1'b1;
      err_d   = !acc_in_range;
      rd_load = !acc_wr;
    end
    if ((state_q == ST_RESP) && wr_q && acc_in_range && !rst) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_gnt     <= 1'b0;
      data_err     <= 1'b0;
      data_rd_data <= '0;
    end else begin
      data_gnt <= gnt_d;
      data_err <= err_d;
      if (rd_load) begin
        data_rd_data <= acc_in_range ? mem[acc_idx] : '0;
      end
    end
  end

  // Request capture; only sampled at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= data_addr;
      wdata_q <= data_wr_data;
      mask_q  <= data_wr_mask;
      wr_q    <= data_wr_req;
    end
  end

  // Storage array is intentionally never reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[acc_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
